// File: rtl/audio_wave_oscillator.sv
// Phase-accumulator oscillator (saw / variable-duty square / triangle / silence)
// with an AXI-Stream master output; one sample is produced per accepted transfer.
module audio_wave_oscillator #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ACC_W  = 32,
  parameter int unsigned DUTY_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ACC_W-1:0]  divisor,
  input  logic [DUTY_W-1:0] duty,
  input  logic [1:0]        waveform,
  input  logic              phase_sync,
  output logic              tvalid,
  output logic [DATA_W-1:0] tdata,
  input  logic              tready,
  output logic              wrap
);

  typedef enum logic {
    ST_PRIME,
    ST_STREAM
  } state_e;

  typedef enum logic [1:0] {
    WF_SAW    = 2'd0,
    WF_SQUARE = 2'd1,
    WF_TRI    = 2'd2,
    WF_SILENT = 2'd3
  } wave_e;

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   phase_q, phase_d;
  logic [DATA_W-1:0]  tdata_q, tdata_d;
  logic               wrap_q, wrap_d;
  logic               sync_pend_q, sync_pend_d;

  logic [ACC_W:0]     sum;
  logic [ACC_W-1:0]   duty_thr;
  logic               sync;

  // Square threshold is duty left-aligned into the accumulator width.
  function automatic logic [DATA_W-1:0] wave_f(
    input logic [ACC_W-1:0] p,
    input logic [ACC_W-1:0] thr,
    input wave_e            wf
  );
    logic [DATA_W-1:0] t;
    logic [DATA_W-1:0] u;
    logic [DATA_W-1:0] r;
    t = p[ACC_W-2 -: DATA_W];
    u = p[ACC_W-1] ? ~t : t;
    r = '0;
    unique case (wf)
      WF_SAW:    r = {~p[ACC_W-1], p[ACC_W-2 -: DATA_W-1]};
      WF_SQUARE: r = (p < thr) ? {1'b0, {(DATA_W-1){1'b1}}}
                               : {1'b1, {(DATA_W-1){1'b0}}};
      WF_TRI:    r = {~u[DATA_W-1], u[DATA_W-2:0]};
      WF_SILENT: r = '0;
      default:   r = '0;
    endcase
    return r;
  endfunction

  assign duty_thr = ACC_W'(duty) << (ACC_W - DUTY_W);
  assign sum      = {1'b0, phase_q} + {1'b0, divisor};
  assign sync     = sync_pend_q | phase_sync;

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    tdata_d     = tdata_q;
    wrap_d      = wrap_q;
    sync_pend_d = sync_pend_q | phase_sync;
    unique case (state_q)
      ST_PRIME: begin
        state_d = ST_STREAM;
        tdata_d = wave_f('0, duty_thr, wave_e'(waveform));
        wrap_d  = 1'b0;
      end
      ST_STREAM: begin
        // A pending or same-edge sync replaces the add for this transfer only.
        if (tready) begin
          phase_d     = sync ? '0 : sum[ACC_W-1:0];
          wrap_d      = ~sync & sum[ACC_W];
          tdata_d     = wave_f(phase_d, duty_thr, wave_e'(waveform));
          sync_pend_d = 1'b0;
        end
      end
      default: state_d = ST_PRIME;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_PRIME;
      phase_q     <= '0;
      tdata_q     <= '0;
      wrap_q      <= 1'b0;
      sync_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      tdata_q     <= tdata_d;
      wrap_q      <= wrap_d;
      sync_pend_q <= sync_pend_d;
    end
  end

  assign tvalid = (state_q == ST_STREAM);
  assign tdata  = tdata_q;
  assign wrap   = wrap_q;

endmodule

// File: tb/tb_audio_wave_oscillator.sv
// Scoreboard bench: the driver predicts each produced sample from an arithmetic
// model and queues it; a negedge monitor pops and compares on every transfer.
module tb_audio_wave_oscillator;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [31:0] divisor = '0;
  logic [7:0]  duty = '0;
  logic [1:0]  waveform = '0;
  logic        phase_sync = 1'b0;
  logic        tvalid;
  logic [15:0] tdata;
  logic        tready = 1'b0;
  logic        wrap;

  audio_wave_oscillator #(
    .DATA_W(16),
    .ACC_W (32),
    .DUTY_W(8)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .divisor   (divisor),
    .duty      (duty),
    .waveform  (waveform),
    .phase_sync(phase_sync),
    .tvalid    (tvalid),
    .tdata     (tdata),
    .tready    (tready),
    .wrap      (wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    logic        w;
  } samp_t;

  samp_t           q[$];
  int              total = 0;
  int              bad = 0;
  longint unsigned m_phase = 0;
  bit              m_pend = 0;
  bit              m_valid = 0;
  bit              exp_valid = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] mwave(input longint unsigned p, input int unsigned d,
                                        input int unsigned wf);
    longint unsigned t;
    case (wf)
      0: return 16'(((p >> 16) ^ 64'h8000) & 64'hFFFF);
      1: return (p < longint'(d) * 64'h100_0000) ? 16'h7FFF : 16'h8000;
      2: begin
        t = (p >> 15) & 64'hFFFF;
        if (p >= 64'h8000_0000) t = 64'hFFFF - t;
        return 16'(t ^ 64'h8000);
      end
      default: return 16'h0000;
    endcase
  endfunction

  // Predicts what the coming edge produces from the inputs now applied.
  task automatic predict();
    longint unsigned s;
    samp_t e;
    if (!m_valid) begin
      e.d = mwave(0, duty, waveform);
      e.w = 1'b0;
      q.push_back(e);
      m_valid = 1;
      m_pend  = m_pend | phase_sync;
    end else if (tready) begin
      if (m_pend || phase_sync) begin
        m_phase = 0;
        e.w     = 1'b0;
      end else begin
        s       = m_phase + longint'(divisor);
        e.w     = (s >= 64'h1_0000_0000);
        m_phase = s % 64'h1_0000_0000;
      end
      e.d    = mwave(m_phase, duty, waveform);
      m_pend = 0;
      q.push_back(e);
    end else begin
      m_pend = m_pend | phase_sync;
    end
  endtask

  task automatic cycle(input bit rdy, input bit sy);
    tready     = rdy;
    phase_sync = sy;
    predict();
    @(posedge clk);
    #1;
    exp_valid = m_valid;
  endtask

  always @(negedge clk) begin
    samp_t e;
    if (reset_n) begin
      chk("tvalid", tvalid, exp_valid);
      if (tvalid && tready) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL scoreboard: got sample %h with no expected entry", tdata);
        end else begin
          e = q.pop_front();
          chk("tdata", tdata, e.d);
          chk("wrap", wrap, e.w);
        end
      end
    end
  end

  initial begin
    #1 reset_n = 1'b0;
    #2;
    chk("rst_tvalid", tvalid, 0);
    chk("rst_tdata", tdata, 0);
    chk("rst_wrap", wrap, 0);
    repeat (3) @(posedge clk);
    #1;
    waveform = 2'd0;
    divisor  = 32'h1000_0000;
    reset_n  = 1'b1;

    // Saw sweep through a full wrap
    repeat (20) cycle(1, 0);
    // Back-pressure mid-stream
    repeat (5) cycle(0, 0);
    repeat (6) cycle(1, 0);

    // Square at 25% then 0% duty
    waveform = 2'd1;
    duty     = 8'd64;
    repeat (34) cycle(1, 0);
    duty = 8'd0;
    repeat (18) cycle(1, 0);

    // Triangle at quarter-cycle steps
    waveform = 2'd2;
    divisor  = 32'h4000_0000;
    repeat (13) cycle(1, 0);

    // Sync pulse captured during a stall
    waveform = 2'd0;
    divisor  = 32'h1000_0000;
    repeat (3) cycle(1, 0);
    cycle(0, 1);
    cycle(0, 0);
    repeat (6) cycle(1, 0);
    cycle(1, 1);
    repeat (3) cycle(1, 0);

    // Asynchronous reset between edges
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_tvalid", tvalid, 0);
    chk("midrst_tdata", tdata, 0);
    chk("midrst_wrap", wrap, 0);
    q.delete();
    m_phase   = 0;
    m_pend    = 0;
    m_valid   = 0;
    exp_valid = 0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (8) cycle(1, 0);

    // Randomised traffic with occasional setting changes and edge divisors
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 31) == 0) begin
        waveform = 2'($urandom_range(0, 3));
        duty     = 8'($urandom);
        case ($urandom_range(0, 3))
          0:       divisor = 32'h0;
          1:       divisor = 32'hFFFF_FFFF;
          default: divisor = $urandom;
        endcase
      end
      cycle($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
